// File: rtl/tetris_input_ctrl.sv
`timescale 1ns/1ps
// tetris_input_ctrl
// Turns the five raw player buttons into single-cycle command strobes for
// tetris_fsm. Each lane is synchronized and debounced, and a strobe is
// emitted on the debounced rising edge. Left/right auto-repeat while held.
// Opposite direction and rotation commands cancel each other so the FSM
// never sees both in the same cycle.
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 3000000,
  parameter int REPEAT_RATE     = 1000000
) (
  input  logic clk,
  input  logic nRst_i,
  input  logic btn_right_i,
  input  logic btn_left_i,
  input  logic btn_rr_i,
  input  logic btn_rl_i,
  input  logic btn_start_i,
  output logic right_o,
  output logic left_o,
  output logic rr_o,
  output logic rl_o,
  output logic en_o
);

  localparam int NUM_LANES  = 5;
  localparam int LANE_RIGHT = 0;
  localparam int LANE_LEFT  = 1;
  localparam int LANE_RR    = 2;
  localparam int LANE_RL    = 3;
  localparam int LANE_START = 4;

  // Only right (index 0) and left (index 1) carry auto-repeat logic.
  localparam int NUM_REP = 2;
  localparam int REP_RIGHT = 0;
  localparam int REP_LEFT  = 1;

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [REP_W-1:0] REP_DLY   = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RT    = REP_W'(REPEAT_RATE);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0] REP_SAT   = REP_W'(REP_MAX);

  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_WAIT1 = 2'd1,
    REP_RUN   = 2'd2
  } rep_state_e;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] sync_meta;
  logic [NUM_LANES-1:0] sync_out;
  logic [NUM_LANES-1:0] stable;
  logic [NUM_LANES-1:0] stable_q;
  logic [NUM_LANES-1:0] press;
  logic [DEB_W-1:0]     deb_cnt [NUM_LANES];

  rep_state_e           rep_state     [NUM_REP];
  rep_state_e           rep_state_nxt [NUM_REP];
  logic [REP_W-1:0]     rep_cnt       [NUM_REP];
  logic [REP_W-1:0]     rep_cnt_nxt   [NUM_REP];
  logic [NUM_REP-1:0]   rep_fire;
  logic [NUM_REP-1:0]   rep_stable;
  logic [NUM_REP-1:0]   rep_press;

  logic right_evt;
  logic left_evt;

  assign raw = {btn_start_i, btn_rl_i, btn_rr_i, btn_left_i, btn_right_i};

  // Two-flop synchronizer bringing every asynchronous button into clk.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // Debounce: the stable bit only follows the synchronized input after it
  // has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      stable <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sync_out[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync_out[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
        end
      end
    end
  end

  // Delayed copy of the debounced state for rising-edge detection.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable;
    end
  end

  assign press = stable & ~stable_q;

  assign rep_stable = {stable[LANE_LEFT], stable[LANE_RIGHT]};
  assign rep_press  = {press[LANE_LEFT],  press[LANE_RIGHT]};

  // Auto-repeat state and counter registers for the two direction lanes.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      for (int j = 0; j < NUM_REP; j++) begin
        rep_state[j] <= REP_IDLE;
        rep_cnt[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_REP; j++) begin
        rep_state[j] <= rep_state_nxt[j];
        rep_cnt[j]   <= rep_cnt_nxt[j];
      end
    end
  end

  // Auto-repeat next state: the counter holds the number of cycles since
  // the last press or repeat event, so comparing it to the delay/rate
  // places repeats exactly DELAY then every RATE cycles after the press.
  always_comb begin
    for (int j = 0; j < NUM_REP; j++) begin
      rep_state_nxt[j] = rep_state[j];
      rep_cnt_nxt[j]   = rep_cnt[j];
      rep_fire[j]      = 1'b0;

      if (!rep_stable[j]) begin
        rep_state_nxt[j] = REP_IDLE;
        rep_cnt_nxt[j]   = '0;
      end else begin
        case (rep_state[j])
          REP_IDLE: begin
            if (rep_press[j]) begin
              rep_state_nxt[j] = REP_WAIT1;
              rep_cnt_nxt[j]   = REP_ONE;
            end else begin
              rep_cnt_nxt[j]   = '0;
            end
          end
          REP_WAIT1: begin
            if (rep_cnt[j] == REP_DLY) begin
              rep_fire[j]      = 1'b1;
              rep_state_nxt[j] = REP_RUN;
              rep_cnt_nxt[j]   = REP_ONE;
            end else if (rep_cnt[j] != REP_SAT) begin
              rep_cnt_nxt[j]   = rep_cnt[j] + REP_ONE;
            end
          end
          REP_RUN: begin
            if (rep_cnt[j] == REP_RT) begin
              rep_fire[j]      = 1'b1;
              rep_cnt_nxt[j]   = REP_ONE;
            end else if (rep_cnt[j] != REP_SAT) begin
              rep_cnt_nxt[j]   = rep_cnt[j] + REP_ONE;
            end
          end
          default: begin
            rep_state_nxt[j] = REP_IDLE;
            rep_cnt_nxt[j]   = '0;
          end
        endcase
      end
    end
  end

  assign right_evt = press[LANE_RIGHT] | rep_fire[REP_RIGHT];
  assign left_evt  = press[LANE_LEFT]  | rep_fire[REP_LEFT];

  // Registered strobes; a held opposite button masks both presses and repeats.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      right_o <= 1'b0;
      left_o  <= 1'b0;
      rr_o    <= 1'b0;
      rl_o    <= 1'b0;
      en_o    <= 1'b0;
    end else begin
      right_o <= right_evt & ~stable[LANE_LEFT];
      left_o  <= left_evt & ~stable[LANE_RIGHT];
      rr_o    <= press[LANE_RR] & ~stable[LANE_RL];
      rl_o    <= press[LANE_RL] & ~stable[LANE_RR];
      en_o    <= press[LANE_START];
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
`timescale 1ns/1ps
// tb_tetris_input_ctrl
// Directed bench for tetris_input_ctrl with short debounce/repeat periods.
// Every cycle the five strobes are compared against a queue of expected
// pulses (edge number + strobe vector); any cycle without a queued entry
// must show all strobes low.
module tb_tetris_input_ctrl;

  localparam int DEB   = 4;
  localparam int RDLY  = 10;
  localparam int RRATE = 5;

  // Strobe vector layout: {en, rl, rr, left, right}
  localparam logic [4:0] V_RIGHT = 5'b00001;
  localparam logic [4:0] V_LEFT  = 5'b00010;
  localparam logic [4:0] V_RR    = 5'b00100;
  localparam logic [4:0] V_RL    = 5'b01000;
  localparam logic [4:0] V_EN    = 5'b10000;

  logic clk = 1'b0;
  logic nRst_i = 1'b0;
  logic btn_right_i = 1'b0;
  logic btn_left_i  = 1'b0;
  logic btn_rr_i    = 1'b0;
  logic btn_rl_i    = 1'b0;
  logic btn_start_i = 1'b0;
  logic right_o, left_o, rr_o, rl_o, en_o;

  typedef struct {
    int         edge_no;
    logic [4:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   base;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE)
  ) dut (
    .clk        (clk),
    .nRst_i     (nRst_i),
    .btn_right_i(btn_right_i),
    .btn_left_i (btn_left_i),
    .btn_rr_i   (btn_rr_i),
    .btn_rl_i   (btn_rl_i),
    .btn_start_i(btn_start_i),
    .right_o    (right_o),
    .left_o     (left_o),
    .rr_o       (rr_o),
    .rl_o       (rl_o),
    .en_o       (en_o)
  );

  always #5 clk = ~clk;

  task automatic pushExpect(input int edge_no, input logic [4:0] vec);
    exp_t e;
    e.edge_no = edge_no;
    e.vec     = vec;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic rr,
                               input logic rl, input logic st);
    btn_right_i = r;
    btn_left_i  = l;
    btn_rr_i    = rr;
    btn_rl_i    = rl;
    btn_start_i = st;
  endtask

  task automatic checkOutput(input string tag);
    logic [4:0] expected;
    logic [4:0] observed;
    exp_t       head;
    expected = 5'b00000;
    if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
      head     = exp_q.pop_front();
      expected = head.vec;
    end
    observed = {en_o, rl_o, rr_o, left_o, right_o};
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, observed, expected);
    end
  endtask

  // Advance n rising edges, checking the strobes 1ns after each edge.
  task automatic tick(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      checkOutput(tag);
    end
  endtask

  initial begin
    // Reset with the four direction/rotation buttons held. After release
    // every pair cancels; once left/rl are dropped only right's repeat
    // slots can reach the output (rr has no repeat).
    nRst_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(4, "reset_hold");
    nRst_i = 1'b1;
    base = cyc;
    tick(8, "reset_release");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pushExpect(base + 17, V_RIGHT);
    pushExpect(base + 22, V_RIGHT);
    tick(10, "reset_drop_opp");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(16, "reset_release_all");

    // Clean start press: one strobe DEB+2 edges after the sampling edge.
    base = cyc;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExpect(base + 1 + DEB + 2, V_EN);
    tick(40, "start_press");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(15, "start_release");

    // Glitchy rr: 3 high, 2 low, 3 high never completes a debounce.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(3, "glitch_hi1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2, "glitch_lo");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(3, "glitch_hi2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(12, "glitch_after");

    // Right held 30 cycles: press at edge 6, repeats at 16, 21, 26, 31.
    base = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExpect(base + 7, V_RIGHT);
    pushExpect(base + 7 + RDLY, V_RIGHT);
    pushExpect(base + 7 + RDLY + RRATE, V_RIGHT);
    pushExpect(base + 7 + RDLY + 2 * RRATE, V_RIGHT);
    pushExpect(base + 7 + RDLY + 3 * RRATE, V_RIGHT);
    tick(30, "repeat_hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(20, "repeat_release");

    // Left+right together: both presses cancel; left's stable falls at
    // base+18, so right resumes at its base+22 slot and, with right
    // released at base+23, gets one last slot at base+27.
    base = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pushExpect(base + 22, V_RIGHT);
    pushExpect(base + 27, V_RIGHT);
    tick(12, "lr_both");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(11, "lr_left_up");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(20, "lr_release");

    // rr+rl together: both cancel and rotation never repeats.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(12, "rot_both");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(11, "rot_rl_up");
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    tick(20, "rot_release");

    // Reset in the middle of an rl debounce; the held button is a fresh
    // press after reset with the full latency.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(4, "midrst_press");
    nRst_i = 1'b0;
    #1;
    checkOutput("midrst_assert");
    tick(5, "midrst_hold");
    nRst_i = 1'b1;
    base = cyc;
    pushExpect(base + 7, V_RL);
    tick(20, "midrst_release");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(15, "midrst_end");

    // Every queued pulse must have been consumed.
    tests_run++;
    assert (exp_q.size() === 0) else begin
      tests_failed++;
      $error("[TB] FAIL leftover_expect observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
